dm_port_arbiter: RTL
====================

Name: dm_port_arbiter

Overview:
- Shares the single-port data memory (DM) between two requesters.
- Port A is the pipeline MEM stage and has priority. Port B is a secondary master, e.g. a program/data loader or debug DMA.
- Fixed priority for A, with a starvation guard that forces a grant to B after a bounded wait.
- Tracks DM's one-cycle read latency and returns each read to the port that issued it.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- STARVE_LIMIT, 4, consecutive denied cycles for B before B is forced ahead of A (1..15).
- PROT_BASE, 16'hF000, lowest address that port B may not write (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a_req  in  1  port A access request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  AW  port A address
- a_wdata  in  DW  port A write data
- a_gnt  out  1  port A granted this cycle
- a_stall  out  1  a_req & ~a_gnt; pipeline must hold MEM stage
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DW  port A read data
- b_req, b_we, b_addr, b_wdata  in  1/1/AW/DW  port B request, same meaning as port A
- b_gnt  out  1  port B granted
- b_rvalid  out  1  port B read data valid
- b_rdata  out  DW  port B read data
- b_err  out  1  port B write blocked (optional feature only; else tied 0)
- dm_addr  out  AW  DM address
- dm_re  out  1  DM read enable
- dm_we  out  1  DM write enable
- dm_in  out  DW  DM write data
- dm_out  in  DW  DM read data, valid the cycle after dm_re

Behaviour:
- Grant is combinational, same cycle as request. At most one grant per cycle.
  - force_b = (starve_cnt == STARVE_LIMIT).
  - a_gnt = a_req & ~(force_b & b_req).
  - b_gnt = b_req & (~a_req | force_b).
- DM drive:
  - dm_addr/dm_in come from the granted port.
  - dm_re = gnt & ~we; dm_we = gnt & we.
  - With no grant: dm_re = dm_we = 0, and dm_addr/dm_in = 0.
- Requester contract: hold req/we/addr/wdata stable until gnt is seen. Deasserting req before gnt is legal and cancels the request.
- starve_cnt (4-bit register):
  - If b_req & ~b_gnt: increment, saturating at STARVE_LIMIT.
  - If b_gnt or ~b_req: clear to 0.
  - force_b therefore lasts exactly one grant. It is followed by at least STARVE_LIMIT cycles of A priority.
- Read return tracking:
  - A 2-bit register {rd_pend, rd_owner} captures {dm_re, b_gnt} at each clock edge.
  - Next cycle: a_rvalid = rd_pend & ~rd_owner; b_rvalid = rd_pend & rd_owner.
  - a_rdata = b_rdata = dm_out, unqualified; consumers qualify with rvalid.
  - Read latency is 1 cycle. A new access may be granted in the cycle its predecessor's data returns (back-to-back, full throughput).
- Writes produce no rvalid.
- Reset (synchronous, rst=1 at posedge):
  - starve_cnt=0, rd_pend=0, b_err register=0.
  - a_rvalid/b_rvalid are 0 in the cycle after reset.
  - A read granted in the same cycle rst is sampled is dropped: no rvalid.
  - Combinational outputs follow inputs even during reset. The pipeline keeps req low during reset.
- Simultaneous a_req & b_req with starve_cnt < STARVE_LIMIT: A wins, B stalls, starve_cnt increments.
- b_req alone: immediate grant, starve_cnt=0.

Optional Feature:
- Macro DM_ARB_PROTECT_EN.
- When defined:
  - A port B write with b_addr >= PROT_BASE is still granted (the handshake completes) but dm_we is held 0.
  - b_err pulses 1 for one cycle, the cycle after the blocked grant.
  - Port B reads and all port A accesses are unaffected.
- When undefined:
  - No address compare.
  - b_err is constant 0 and all granted writes reach DM.

Test Plan:
- Reset: rst=1 for 2 cycles with a_req=b_req=0 -> all gnt/rvalid/err=0, dm_re=dm_we=0; after release starve_cnt=0.
- A read: a_req=1, a_we=0, a_addr=0, DM[0]=16'h0A0A -> a_gnt=1 and dm_re=1 same cycle; next cycle a_rvalid=1, a_rdata=16'h0A0A, b_rvalid=0.
- B write alone: b_req=1, b_we=1, b_addr=2, b_wdata=16'hBABA -> b_gnt=1, dm_we=1; next cycle DM[2]=16'hBABA, no rvalid.
- Starvation: a_req and b_req held high continuously (STARVE_LIMIT=4), B read at addr 5 with DM[5]=16'hABCD -> a_gnt for 4 cycles, a_stall=0; 5th cycle b_gnt=1, a_stall=1; 6th cycle b_rvalid=1, b_rdata=16'hABCD, a_gnt=1 again.
- Back-to-back reads: A reads addr 0 then addr 5 on consecutive cycles -> a_rvalid high 2 consecutive cycles with 16'h0A0A then 16'hABCD.
- Protect (DM_ARB_PROTECT_EN): B write b_addr=16'hF000, data 16'h1234 -> b_gnt=1, dm_we=0, DM[16'hF000] unchanged, b_err=1 next cycle; without the macro, DM[16'hF000]=16'h1234 and b_err=0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// ---------------
// Shares one single-port data memory between two masters.
//   Port A : pipeline MEM stage, fixed priority.
//   Port B : secondary master (loader / debug DMA). It is forced ahead of A
//            once it has been denied STARVE_LIMIT consecutive cycles.
// The DM has a one-cycle read latency. A small tracker remembers who issued
// each read, so the returning data is flagged valid on the right port.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata         port A request
//   a_gnt, a_stall                    port A grant, pipeline hold
//   a_rvalid, a_rdata                 port A read return
//   b_req/b_we/b_addr/b_wdata         port B request
//   b_gnt                             port B grant
//   b_rvalid, b_rdata                 port B read return
//   b_err                             port B blocked-write pulse
//   dm_addr/dm_re/dm_we/dm_in         DM command
//   dm_out                            DM read data, valid the cycle after dm_re
//
// Optional build macro: DM_ARB_PROTECT_EN
//   Defined   : port B writes at or above PROT_BASE are granted but never
//               reach DM, and b_err pulses the cycle after the grant.
//   Undefined : no address compare, b_err tied 0.
module dm_port_arbiter #(
  parameter int              AW           = 16,
  parameter int              DW           = 16,
  parameter int              STARVE_LIMIT = 4,
  parameter logic [AW-1:0]   PROT_BASE    = AW'('hF000)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_stall,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic [AW-1:0] dm_addr,
  output logic          dm_re,
  output logic          dm_we,
  output logic [DW-1:0] dm_in,
  input  logic [DW-1:0] dm_out
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starveCnt_q, starveCnt_d;
  logic       rdPend_q, rdOwner_q;
  logic       forceB;
  logic       bBlock;

  // B wins exactly once when its wait counter reaches the limit; otherwise A
  // keeps fixed priority. At most one grant can be high.
  assign forceB  = (starveCnt_q == LIMIT);
  assign a_gnt   = a_req & ~(forceB & b_req);
  assign b_gnt   = b_req & (~a_req | forceB);
  assign a_stall = a_req & ~a_gnt;

`ifdef DM_ARB_PROTECT_EN
  // A blocked B write still completes its handshake; only the DM strobe is
  // suppressed so the requester never hangs waiting for a grant.
  logic bErr_q;

  assign bBlock = b_gnt & b_we & (b_addr >= PROT_BASE);
  assign b_err  = bErr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bErr_q <= 1'b0;
    end else begin
      bErr_q <= bBlock;
    end
  end
`else
  // Without protection every granted write reaches DM. PROT_BASE is folded
  // into a sink so the parameter list stays identical between builds.
  logic unusedProtBase;

  assign unusedProtBase = ^PROT_BASE;
  assign bBlock         = 1'b0;
  assign b_err          = 1'b0;
`endif

  // DM command mux: the granted port drives address, data and strobes; with
  // no grant everything is driven to zero so DM sees a clean idle bus.
  always_comb begin
    dm_addr = '0;
    dm_in   = '0;
    dm_re   = 1'b0;
    dm_we   = 1'b0;
    if (a_gnt) begin
      dm_addr = a_addr;
      dm_in   = a_wdata;
      dm_re   = ~a_we;
      dm_we   = a_we;
    end else if (b_gnt) begin
      dm_addr = b_addr;
      dm_in   = b_wdata;
      dm_re   = ~b_we;
      dm_we   = b_we & ~bBlock;
    end
  end

  // Starvation counter: counts consecutive cycles B is waiting and clears the
  // moment B is served or withdraws. Saturation keeps it from wrapping past
  // the limit even if B were somehow still denied there.
  always_comb begin
    starveCnt_d = 4'd0;
    if (b_req & ~b_gnt) begin
      starveCnt_d = (starveCnt_q == LIMIT) ? starveCnt_q : starveCnt_q + 4'd1;
    end
  end

  // State registers: starvation count plus the read-return tracker. The
  // tracker samples dm_re and the owner each edge; reset drops any read
  // granted in the reset cycle so no stray rvalid follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt_q <= 4'd0;
      rdPend_q    <= 1'b0;
      rdOwner_q   <= 1'b0;
    end else begin
      starveCnt_q <= starveCnt_d;
      rdPend_q    <= dm_re;
      rdOwner_q   <= b_gnt;
    end
  end

  // Read data is shared and unqualified; rvalid steers it to the owner.
  assign a_rvalid = rdPend_q & ~rdOwner_q;
  assign b_rvalid = rdPend_q & rdOwner_q;
  assign a_rdata  = dm_out;
  assign b_rdata  = dm_out;

endmodule
